// File: rtl/cla24_share_arbiter.sv
// Round-robin arbiter sharing one 24-bit carry-lookahead adder among N_REQ requesters; 1-cycle latency, one-entry output register.
// Grants are withheld while the result is FULL and not drained. Optional multi-word carry chaining under `CLA_SHARE_CHAIN_EN.
module cla24_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req_valid,
  output logic [N_REQ-1:0]      o_req_ready,
  input  logic [N_REQ*24-1:0]   i_req_a,
  input  logic [N_REQ*24-1:0]   i_req_b,
  input  logic [N_REQ-1:0]      i_req_sub,
`ifdef CLA_SHARE_CHAIN_EN
  input  logic [N_REQ-1:0]      i_req_chain,
`endif
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [23:0]           o_rsp_sum,
  output logic                  o_rsp_carry,
  output logic [ID_W-1:0]       o_rsp_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [23:0]       sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              grant_en;
  logic [N_REQ-1:0]  eligible;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [N_REQ-1:0]  grant_oh;
  logic [23:0]       op_a, op_b, op_b_eff;
  logic              op_sub, op_cin;
  logic [24:0]       add_res;
  int                scan_idx;
  int                ptr_nxt;

`ifdef CLA_SHARE_CHAIN_EN
  logic              lock_q, lock_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic              chain_c_q, chain_c_d;
  logic [N_REQ-1:0]  lock_mask;
  logic              op_chain;
`endif

  // Two-level lookahead: 4-bit group generate/propagate, carries rippled inside each group.
  function automatic logic [24:0] cla24(input logic [23:0] a, input logic [23:0] b, input logic cin);
    logic [23:0] g, p;
    logic [24:0] c;
    logic [6:0]  bc;
    logic        bg, bp;
    g = a & b;
    p = a ^ b;
    c = '0;
    bc = '0;
    bc[0] = cin;
    for (int k = 0; k < 6; k++) begin
      bg = 1'b0;
      bp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        bg = g[4*k+j] | (p[4*k+j] & bg);
        bp = bp & p[4*k+j];
      end
      bc[k+1] = bg | (bp & bc[k]);
    end
    for (int k = 0; k < 6; k++) begin
      c[4*k] = bc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[24] = bc[6];
    return {c[24], p ^ c[23:0]};
  endfunction

  always_comb begin
    grant_en = (state_q == EMPTY) | i_rsp_ready;
    eligible = i_req_valid & {N_REQ{grant_en & i_rst_n}};
`ifdef CLA_SHARE_CHAIN_EN
    lock_mask = '1;
    if (lock_q) begin
      lock_mask = '0;
      lock_mask[lock_id_q] = 1'b1;
    end
    eligible = eligible & lock_mask;
`endif
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = (int'(rr_ptr_q) + i) % N_REQ;
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[ID_W-1:0];
      end
    end
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  assign o_req_ready = grant_oh;

  always_comb begin
    op_a     = i_req_a[int'(grant_idx)*24 +: 24];
    op_b     = i_req_b[int'(grant_idx)*24 +: 24];
    op_sub   = i_req_sub[grant_idx];
    op_b_eff = op_sub ? ~op_b : op_b;
    op_cin   = op_sub;
`ifdef CLA_SHARE_CHAIN_EN
    op_chain = i_req_chain[grant_idx];
    if (lock_q) op_cin = chain_c_q;
`endif
    add_res = cla24(op_a, op_b_eff, op_cin);
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    id_d     = id_q;
    ptr_nxt  = int'(grant_idx) + 1;
    if (ptr_nxt >= N_REQ) ptr_nxt = 0;
`ifdef CLA_SHARE_CHAIN_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    chain_c_d = chain_c_q;
`endif
    if (grant_vld) begin
      state_d = FULL;
      sum_d   = add_res[23:0];
      carry_d = add_res[24];
      id_d    = grant_idx;
`ifdef CLA_SHARE_CHAIN_EN
      // The pointer only moves once a chained sequence is closed.
      if (op_chain) begin
        lock_d    = 1'b1;
        lock_id_d = grant_idx;
        chain_c_d = add_res[24];
      end else begin
        lock_d   = 1'b0;
        rr_ptr_d = ptr_nxt[ID_W-1:0];
      end
`else
      rr_ptr_d = ptr_nxt[ID_W-1:0];
`endif
    end else if (i_rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      id_q     <= '0;
`ifdef CLA_SHARE_CHAIN_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      chain_c_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      id_q     <= id_d;
`ifdef CLA_SHARE_CHAIN_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      chain_c_q <= chain_c_d;
`endif
    end
  end

  assign o_rsp_valid = (state_q == FULL);
  assign o_rsp_sum   = sum_q;
  assign o_rsp_carry = carry_q;
  assign o_rsp_id    = id_q;

endmodule

// File: tb/tb_cla24_share_arbiter.sv
// Bench for cla24_share_arbiter: scoreboard of expected results fed from granted requests, drained on response handshakes.
module tb_cla24_share_arbiter;
  localparam int N = 4;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [N-1:0]    i_req_valid = '0;
  logic [N-1:0]    o_req_ready;
  logic [N*24-1:0] i_req_a, i_req_b;
  logic [N-1:0]    i_req_sub = '0;
  logic [N-1:0]    i_req_chain = '0;
  logic            o_rsp_valid;
  logic            i_rsp_ready = 1'b1;
  logic [23:0]     o_rsp_sum;
  logic            o_rsp_carry;
  logic [1:0]      o_rsp_id;

  logic [23:0] a_m [N];
  logic [23:0] b_m [N];

  always #5 i_clk = ~i_clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      i_req_a[24*k +: 24] = a_m[k];
      i_req_b[24*k +: 24] = b_m[k];
    end
  end

  cla24_share_arbiter #(.N_REQ(N)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_sub(i_req_sub),
`ifdef CLA_SHARE_CHAIN_EN
    .i_req_chain(i_req_chain),
`endif
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_sum(o_rsp_sum), .o_rsp_carry(o_rsp_carry), .o_rsp_id(o_rsp_id)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  id;
    logic [23:0] sum;
    logic        carry;
  } exp_t;
  exp_t sb[$];

  // Arithmetic reference: a + b + cin for add, a - b - (1 - cin) for subtract, carry = no overflow/borrow.
  function automatic logic [24:0] ref_op(input logic [23:0] a, input logic [23:0] b, input logic sub, input logic cin);
    longint t;
    if (sub) t = longint'(a) - longint'(b) - 1 + longint'(cin) + 64'h100_0000;
    else     t = longint'(a) + longint'(b) + longint'(cin);
    return t[24:0];
  endfunction

  // Monitor and reference model, evaluated on the falling edge.
  logic        full_m = 1'b0;
  int          ptr_m = 0;
  logic        lock_m = 1'b0;
  int          lock_id_m = 0;
  logic        lock_c_m = 1'b0;
  logic [N-1:0] exp_rdy;
  int          g;
  logic        cin_m;
  logic [24:0] r;
  exp_t        e;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("rst_req_ready", 64'(o_req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
      chk("rst_rsp_sum", 64'(o_rsp_sum), 64'd0);
      chk("rst_rsp_carry", 64'(o_rsp_carry), 64'd0);
      chk("rst_rsp_id", 64'(o_rsp_id), 64'd0);
      full_m = 1'b0; ptr_m = 0; lock_m = 1'b0;
      sb.delete();
    end else begin
      chk("rsp_valid", 64'(o_rsp_valid), 64'(full_m));
      if (full_m && i_rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 64'(o_rsp_id), 64'(e.id));
          chk("rsp_sum", 64'(o_rsp_sum), 64'(e.sum));
          chk("rsp_carry", 64'(o_rsp_carry), 64'(e.carry));
        end
      end
      g = -1;
      if (!full_m || i_rsp_ready) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (ptr_m + i) % N;
          if (g < 0 && i_req_valid[k] && (!lock_m || lock_id_m == k)) g = k;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(o_req_ready), 64'(exp_rdy));
      if (g >= 0) begin
        cin_m = lock_m ? lock_c_m : i_req_sub[g];
        r = ref_op(a_m[g], b_m[g], i_req_sub[g], cin_m);
        e.id = 2'(g); e.sum = r[23:0]; e.carry = r[24];
        sb.push_back(e);
        full_m = 1'b1;
`ifdef CLA_SHARE_CHAIN_EN
        if (i_req_chain[g]) begin
          lock_m = 1'b1; lock_id_m = g; lock_c_m = r[24];
        end else begin
          lock_m = 1'b0; ptr_m = (g + 1) % N;
        end
`else
        ptr_m = (g + 1) % N;
`endif
      end else if (i_rsp_ready) begin
        full_m = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    i_req_valid = '0;
    i_req_chain = '0;
    tick(); tick();
    i_rst_n = 1'b1;
  endtask

  task automatic set_req(input int k, input logic [23:0] a, input logic [23:0] b, input logic sub);
    a_m[k] = a; b_m[k] = b; i_req_sub[k] = sub; i_req_valid[k] = 1'b1;
  endtask

  // Holds request k until it is granted, then drops its valid after the transfer edge.
  task automatic wait_grant(input int k);
    bit got;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge i_clk);
      if (o_req_ready[k]) got = 1;
    end
    if (!got) chk("grant_timeout", 64'd0, 64'd1);
    tick();
    i_req_valid[k] = 1'b0;
  endtask

  logic [23:0] held_sum;
  logic [1:0]  held_id;
  logic [N-1:0] granted_last;

  initial begin
    for (int k = 0; k < N; k++) begin a_m[k] = '0; b_m[k] = '0; end
    tick(); tick();
    i_rst_n = 1'b1;
    tick();

    // Single add with wraparound carry.
    set_req(0, 24'h000001, 24'hFFFFFF, 1'b0);
    @(negedge i_clk);
    chk("add_ready0", 64'(o_req_ready), 64'h1);
    tick(); i_req_valid[0] = 1'b0;
    @(negedge i_clk);
    chk("add_sum", 64'(o_rsp_sum), 64'h0);
    chk("add_carry", 64'(o_rsp_carry), 64'h1);
    chk("add_id", 64'(o_rsp_id), 64'h0);
    tick();

    // Subtracts with and without borrow.
    set_req(2, 24'd5, 24'd3, 1'b1);
    wait_grant(2);
    set_req(2, 24'd3, 24'd5, 1'b1);
    @(negedge i_clk);
    chk("sub1_sum", 64'(o_rsp_sum), 64'h2);
    chk("sub1_carry", 64'(o_rsp_carry), 64'h1);
    wait_grant(2);
    @(negedge i_clk);
    chk("sub2_sum", 64'(o_rsp_sum), 64'hFFFFFE);
    chk("sub2_carry", 64'(o_rsp_carry), 64'h0);
    chk("sub2_id", 64'(o_rsp_id), 64'h2);
    tick();

    // Round-robin from reset with all requesters valid.
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 24'(k * 24'h111111), 24'(k + 1), k[0]);
    tick();
    for (int c = 0; c < 6; c++) begin
      logic [1:0] want;
      want = 2'(c % N);
      @(negedge i_clk);
      chk("rr_id", 64'(o_rsp_id), 64'(want));
      chk("rr_valid", 64'(o_rsp_valid), 64'h1);
      tick();
    end

    // Backpressure: hold FULL for three cycles.
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    held_sum = o_rsp_sum; held_id = o_rsp_id;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge i_clk);
      chk("bp_ready", 64'(o_req_ready), 64'h0);
      chk("bp_sum_hold", 64'(o_rsp_sum), 64'(held_sum));
      chk("bp_id_hold", 64'(o_rsp_id), 64'(held_id));
    end
    tick();
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_regrant", 64'(|o_req_ready), 64'h1);
    tick();
    i_req_valid = '0;
    tick(); tick();

    // Reset while FULL with req1 pending.
    i_rsp_ready = 1'b0;
    set_req(1, 24'h123456, 24'h000111, 1'b0);
    tick(); tick();
    i_rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(o_rsp_valid), 64'h0);
    i_rsp_ready = 1'b1;
    i_req_valid = '1;
    tick(); tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_grant", 64'(o_req_ready), 64'h1);
    tick();
    i_req_valid = '0;
    tick(); tick();

`ifdef CLA_SHARE_CHAIN_EN
    // Chained 48-bit add on req1 while req2 waits.
    do_reset();
    set_req(1, 24'hFFFFFF, 24'h000001, 1'b0);
    i_req_chain[1] = 1'b1;
    set_req(2, 24'h000010, 24'h000020, 1'b0);
    @(negedge i_clk);
    chk("chain_first_ready", 64'(o_req_ready), 64'h2);
    tick();
    set_req(1, 24'h0, 24'h0, 1'b0);
    i_req_chain[1] = 1'b0;
    @(negedge i_clk);
    chk("chain_lo_sum", 64'(o_rsp_sum), 64'h0);
    chk("chain_lo_carry", 64'(o_rsp_carry), 64'h1);
    chk("chain_locked_ready", 64'(o_req_ready), 64'h2);
    tick();
    i_req_valid[1] = 1'b0;
    @(negedge i_clk);
    chk("chain_hi_sum", 64'(o_rsp_sum), 64'h1);
    chk("chain_req2_after", 64'(o_req_ready), 64'h4);
    tick();
    i_req_valid = '0;
    tick(); tick();
`endif

    // Random traffic; unserved requesters keep their request stable.
    granted_last = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge i_clk);
      granted_last = o_req_ready;
      tick();
      for (int k = 0; k < N; k++) begin
        if (!i_req_valid[k] || granted_last[k]) begin
          i_req_valid[k] = ($urandom_range(0, 1) == 1);
          a_m[k] = 24'($urandom);
          b_m[k] = 24'($urandom);
          i_req_sub[k] = 1'($urandom);
          i_req_chain[k] = ($urandom_range(0, 4) == 0);
        end
      end
      i_rsp_ready = ($urandom_range(0, 9) < 7);
    end

    i_req_valid = '0;
    i_req_chain = '0;
    i_rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
